// File: rtl/leopard_seq_pkg.sv
// Shared types for the leopard voice sequencer: opcodes, FSM states,
// the queued command bundle and the per-voice controls strobe bit map.
package leopard_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_SET_PITCH  = 3'd1,
    OP_SET_VOLUME = 3'd2,
    OP_SET_OCTAVE = 3'd3,
    OP_WRITE_BYTE = 3'd4,
    OP_GATE_ON    = 3'd5,
    OP_GATE_OFF   = 3'd6,
    OP_RSVD       = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REG     = 3'd1,
    S_PTR_HI  = 3'd2,
    S_PTR_LO  = 3'd3,
    S_WT_DATA = 3'd4,
    S_GATE    = 3'd5
  } state_e;

  typedef struct packed {
    op_e         op;
    logic [3:0]  voice;
    logic [11:0] addr;
    logic [7:0]  data;
  } cmd_t;

  // Bit positions inside one voice's 8-bit controls strobe group
  localparam logic [2:0] WEN_PTR_HI_OCT = 3'd0;
  localparam logic [2:0] WEN_PTR_LO     = 3'd1;
  localparam logic [2:0] WEN_PITCH      = 3'd2;
  localparam logic [2:0] WEN_VOLUME     = 3'd3;

endpackage

// File: rtl/leopard_cmd_fifo.sv
// Synchronous command FIFO (DEPTH entries, power of two, >= 2).
// Ports: aclk/areset (sync, active-high), i_push/i_din, o_full,
// i_pop/o_dout (head, show-ahead), o_empty.
module leopard_cmd_fifo
  import leopard_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic aclk,
  input  logic areset,
  input  logic i_push,
  input  cmd_t i_din,
  output logic o_full,
  input  logic i_pop,
  output cmd_t o_dout,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  cmd_t        r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  // Extra pointer bit distinguishes full from empty
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  // Full is judged before any same-cycle pop: no bypass
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !w_empty;

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + ONE;
      if (w_pop)  r_rptr <= r_rptr + ONE;
    end
  end

endmodule

// File: rtl/leopard_voice_sequencer.sv
// Expands queued host commands into single-cycle voice strobes and gates.
// Ports: aclk/areset, cmd_* valid/ready push port, voice_controls bus,
// voice_controls_wen / voice_wavetable_wen strobes, voice_gate, busy.
// Option: LEOPARD_SEQ_PTR_CACHE_EN skips pointer strobes that match shadow.
module leopard_voice_sequencer
  import leopard_seq_pkg::*;
#(
  parameter int VOICES     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [3:0]            cmd_voice,
  input  logic [11:0]           cmd_addr,
  input  logic [7:0]            cmd_data,
  output logic [7:0]            voice_controls,
  output logic [VOICES*8-1:0]   voice_controls_wen,
  output logic [VOICES-1:0]     voice_wavetable_wen,
  output logic [VOICES-1:0]     voice_gate,
  output logic                  busy
);

  localparam int WW = VOICES * 8;

  cmd_t              w_din;
  cmd_t              w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_vok;
  logic [VOICES-1:0] w_vmask;

  state_e            r_state;
  cmd_t              r_cmd;
  logic [7:0]        r_ctrl;
  logic [WW-1:0]     r_wen;
  logic [VOICES-1:0] r_wt;
  logic [VOICES-1:0] r_gate;
  // Sized for the full 4-bit voice field; unused entries stay at reset
  logic [11:0]       r_wptr [16];
  logic [3:0]        r_oct  [16];

  assign w_din = '{
    op:    op_e'(cmd_op),
    voice: cmd_voice,
    addr:  cmd_addr,
    data:  cmd_data
  };

  assign w_pop = (r_state == S_IDLE);

  leopard_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .areset  (areset),
    .i_push  (cmd_valid),
    .i_din   (w_din),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_empty (w_empty)
  );

  assign w_vok   = ({1'b0, w_head.voice} < 5'(VOICES));
  assign w_vmask = VOICES'(1) << r_cmd.voice;

`ifdef LEOPARD_SEQ_PTR_CACHE_EN
  logic w_hd_hi_eq;
  logic w_hd_lo_eq;
  logic w_cur_lo_eq;
  assign w_hd_hi_eq  = (w_head.addr[11:8] == r_wptr[w_head.voice][11:8]);
  assign w_hd_lo_eq  = (w_head.addr[7:0] == r_wptr[w_head.voice][7:0]);
  assign w_cur_lo_eq = (r_cmd.addr[7:0] == r_wptr[r_cmd.voice][7:0]);
`endif

  function automatic logic [WW-1:0] wen_bit(
    input logic [3:0] v,
    input logic [2:0] b
  );
    return WW'(1) << {v, b};
  endfunction

  assign cmd_ready           = !w_full;
  assign busy                = !w_empty || (r_state != S_IDLE);
  assign voice_controls      = r_ctrl;
  assign voice_controls_wen  = r_wen;
  assign voice_wavetable_wen = r_wt;
  assign voice_gate          = r_gate;

  // Strobes are registered while in a state, so each shows up
  // the cycle after that state and always drops back to zero.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_ctrl  <= '0;
      r_wen   <= '0;
      r_wt    <= '0;
      r_gate  <= '0;
      for (int i = 0; i < 16; i++) begin
        r_wptr[i] <= '0;
        r_oct[i]  <= '0;
      end
    end else begin
      r_ctrl <= '0;
      r_wen  <= '0;
      r_wt   <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_cmd <= w_head;
            if (!w_vok) begin
              r_state <= S_IDLE;
            end else begin
              case (w_head.op)
                OP_SET_PITCH,
                OP_SET_VOLUME,
                OP_SET_OCTAVE: r_state <= S_REG;
                OP_WRITE_BYTE: begin
`ifdef LEOPARD_SEQ_PTR_CACHE_EN
                  if (!w_hd_hi_eq)      r_state <= S_PTR_HI;
                  else if (!w_hd_lo_eq) r_state <= S_PTR_LO;
                  else                  r_state <= S_WT_DATA;
`else
                  r_state <= S_PTR_HI;
`endif
                end
                OP_GATE_ON,
                OP_GATE_OFF:   r_state <= S_GATE;
                default:       r_state <= S_IDLE;
              endcase
            end
          end
        end
        S_REG: begin
          case (r_cmd.op)
            OP_SET_PITCH: begin
              r_wen  <= wen_bit(r_cmd.voice, WEN_PITCH);
              r_ctrl <= r_cmd.data;
            end
            OP_SET_VOLUME: begin
              r_wen  <= wen_bit(r_cmd.voice, WEN_VOLUME);
              r_ctrl <= r_cmd.data;
            end
            default: begin
              // Octave shares the register with pointer-high bits
              r_wen  <= wen_bit(r_cmd.voice, WEN_PTR_HI_OCT);
              r_ctrl <= {r_cmd.data[3:0], r_wptr[r_cmd.voice][11:8]};
              r_oct[r_cmd.voice] <= r_cmd.data[3:0];
            end
          endcase
          r_state <= S_IDLE;
        end
        S_PTR_HI: begin
          r_wen  <= wen_bit(r_cmd.voice, WEN_PTR_HI_OCT);
          r_ctrl <= {r_oct[r_cmd.voice], r_cmd.addr[11:8]};
`ifdef LEOPARD_SEQ_PTR_CACHE_EN
          r_state <= w_cur_lo_eq ? S_WT_DATA : S_PTR_LO;
`else
          r_state <= S_PTR_LO;
`endif
        end
        S_PTR_LO: begin
          r_wen   <= wen_bit(r_cmd.voice, WEN_PTR_LO);
          r_ctrl  <= r_cmd.addr[7:0];
          r_state <= S_WT_DATA;
        end
        S_WT_DATA: begin
          r_wt    <= w_vmask;
          r_ctrl  <= r_cmd.data;
          r_wptr[r_cmd.voice] <= r_cmd.addr;
          r_state <= S_IDLE;
        end
        S_GATE: begin
          if (r_cmd.op == OP_GATE_ON) r_gate <= r_gate | w_vmask;
          else                        r_gate <= r_gate & ~w_vmask;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leopard_voice_sequencer.sv
// Directed bench for leopard_voice_sequencer (VOICES=4, FIFO_DEPTH=8).
// Strobes are logged at negedges and checked against hand values.
module tb_leopard_voice_sequencer;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [3:0]  cmd_voice = '0;
  logic [11:0] cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic [7:0]  ctrl;
  logic [31:0] wen;
  logic [3:0]  wt;
  logic [3:0]  gate;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] wen;
    logic [3:0]  wt;
    logic [7:0]  ctrl;
    int          cyc;
  } ev_t;
  ev_t q[$];

`ifdef LEOPARD_SEQ_PTR_CACHE_EN
  localparam int N_SAMEPAGE = 2;
  localparam int N_REPEAT   = 1;
`else
  localparam int N_SAMEPAGE = 3;
  localparam int N_REPEAT   = 3;
`endif

  leopard_voice_sequencer #(
    .VOICES     (4),
    .FIFO_DEPTH (8)
  ) dut (
    .aclk                (aclk),
    .areset              (areset),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_op              (cmd_op),
    .cmd_voice           (cmd_voice),
    .cmd_addr            (cmd_addr),
    .cmd_data            (cmd_data),
    .voice_controls      (ctrl),
    .voice_controls_wen  (wen),
    .voice_wavetable_wen (wt),
    .voice_gate          (gate),
    .busy                (busy)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (|wen || |wt) q.push_back('{wen, wt, ctrl, cyc});
    total++;
    assert ($countones({wen, wt}) <= 1) else begin
      bad++;
      $error("FAIL onehot: got %0h want at most one bit", {wen, wt});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [3:0] v,
                      input logic [11:0] a, input logic [7:0] d,
                      output int acc);
    int n;
    cmd_op = op;
    cmd_voice = v;
    cmd_addr = a;
    cmd_data = d;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk("push_timeout", 64'(n < 100), 64'd1);
    acc = cyc + 1;
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge aclk);
    while (busy && n < 200) begin
      @(negedge aclk);
      n++;
    end
    chk(tag, 64'(n < 200), 64'd1);
    repeat (3) @(negedge aclk);
  endtask

  initial begin
    int acc;
    int a0;
    int accs[12];
    int n;

    // Reset state
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_wt", 64'(wt), 64'd0);
    chk("rst_ctrl", 64'(ctrl), 64'd0);
    chk("rst_gate", 64'(gate), 64'd0);

    // SET_PITCH v1: strobe two edges after acceptance
    q.delete();
    push(3'd1, 4'd1, 12'h000, 8'h5A, acc);
    chk("p_busy0", 64'(busy), 64'd1);
    @(negedge aclk);
    chk("p_busy1", 64'(busy), 64'd1);
    chk("p_early", 64'(wen), 64'd0);
    @(negedge aclk);
    chk("p_wen", 64'(wen), 64'h0000_0400);
    chk("p_ctrl", 64'(ctrl), 64'h5A);
    chk("p_busy2", 64'(busy), 64'd0);
    @(negedge aclk);
    chk("p_wen_drop", 64'(wen), 64'd0);
    wait_idle("p_idle");
    chk("p_count", 64'(q.size()), 64'd1);
    chk("p_lat", 64'(q[0].cyc - acc), 64'd2);

    // SET_OCTAVE v0 then WRITE_BYTE v0 3C1
    q.delete();
    push(3'd3, 4'd0, 12'h000, 8'h03, acc);
    push(3'd4, 4'd0, 12'h3C1, 8'h80, acc);
    wait_idle("o_idle");
    chk("o_count", 64'(q.size()), 64'd4);
    chk("o_e0_wen", 64'(q[0].wen), 64'h1);
    chk("o_e0_ctrl", 64'(q[0].ctrl), 64'h30);
    chk("o_e1_wen", 64'(q[1].wen), 64'h1);
    chk("o_e1_ctrl", 64'(q[1].ctrl), 64'h33);
    chk("o_e2_wen", 64'(q[2].wen), 64'h2);
    chk("o_e2_ctrl", 64'(q[2].ctrl), 64'hC1);
    chk("o_e3_wt", 64'(q[3].wt), 64'h1);
    chk("o_e3_ctrl", 64'(q[3].ctrl), 64'h80);
    chk("o_e3_wen", 64'(q[3].wen), 64'h0);
    chk("o_gap1", 64'(q[2].cyc - q[1].cyc), 64'd1);
    chk("o_gap2", 64'(q[3].cyc - q[2].cyc), 64'd1);

    // Page and repeat address writes on v2
    q.delete();
    push(3'd4, 4'd2, 12'h105, 8'h11, acc);
    wait_idle("c1_idle");
    chk("c1_count", 64'(q.size()), 64'd3);
    chk("c1_wt", 64'(q[q.size()-1].wt), 64'h4);
    q.delete();
    push(3'd4, 4'd2, 12'h106, 8'h22, acc);
    wait_idle("c2_idle");
    chk("c2_count", 64'(q.size()), 64'(N_SAMEPAGE));
    chk("c2_wt", 64'(q[q.size()-1].wt), 64'h4);
    chk("c2_ctrl", 64'(q[q.size()-1].ctrl), 64'h22);
    q.delete();
    push(3'd4, 4'd2, 12'h106, 8'h33, acc);
    wait_idle("c3_idle");
    chk("c3_count", 64'(q.size()), 64'(N_REPEAT));
    chk("c3_ctrl", 64'(q[q.size()-1].ctrl), 64'h33);

    // Back-to-back WRITE_BYTEs to v1 fill the FIFO
    q.delete();
    for (int k = 0; k < 12; k++) begin
      logic [3:0] hi;
      logic [7:0] lo;
      hi = 4'(k + 1);
      lo = 8'(k + 1);
      push(3'd4, 4'd1, {hi, lo}, 8'(8'h40 + k), accs[k]);
      if (k == 10) chk("f_ready_low", 64'(cmd_ready), 64'd0);
    end
    wait_idle("f_idle");
    chk("f_acc10", 64'(accs[10] - accs[0]), 64'd10);
    chk("f_acc11", 64'(accs[11] - accs[0]), 64'd14);
    chk("f_count", 64'(q.size()), 64'd36);
    if (q.size() == 36) begin
      for (int k = 0; k < 12; k++) begin
        chk("f_hi", 64'(q[3*k].ctrl), 64'(k + 1));
        chk("f_lo", 64'(q[3*k+1].ctrl), 64'(k + 1));
        chk("f_wt", 64'(q[3*k+2].wt), 64'h2);
        chk("f_data", 64'(q[3*k+2].ctrl), 64'(8'h40 + k));
      end
    end

    // Gate on/off with an out-of-range voice in between
    q.delete();
    push(3'd5, 4'd3, 12'h000, 8'h00, acc);
    push(3'd2, 4'd5, 12'h000, 8'hEE, acc);
    push(3'd6, 4'd3, 12'h000, 8'h00, acc);
    chk("g_rise", 64'(gate), 64'h8);
    wait_idle("g_idle");
    chk("g_fall", 64'(gate), 64'h0);
    chk("g_nostrobe", 64'(q.size()), 64'd0);

    // Reset during PTR_LO
    q.delete();
    push(3'd5, 4'd2, 12'h000, 8'h00, acc);
    push(3'd4, 4'd0, 12'h2AB, 8'h77, acc);
    n = 0;
    while (wen !== 32'h1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    chk("r_reach_lo", 64'(n < 20), 64'd1);
    chk("r_gate_pre", 64'(gate), 64'h4);
    areset = 1'b1;
    @(negedge aclk);
    chk("r_wen", 64'(wen), 64'd0);
    chk("r_wt", 64'(wt), 64'd0);
    chk("r_ctrl", 64'(ctrl), 64'd0);
    chk("r_gate", 64'(gate), 64'd0);
    chk("r_busy", 64'(busy), 64'd0);
    chk("r_ready", 64'(cmd_ready), 64'd1);
    areset = 1'b0;
    repeat (6) @(negedge aclk);
    chk("r_count", 64'(q.size()), 64'd1);
    q.delete();
    push(3'd4, 4'd0, 12'h512, 8'h09, acc);
    wait_idle("r2_idle");
    chk("r2_count", 64'(q.size()), 64'd3);
    chk("r2_hi", 64'(q[0].ctrl), 64'h05);
    chk("r2_lo", 64'(q[1].ctrl), 64'h12);
    chk("r2_data", 64'(q[2].ctrl), 64'h09);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
